// File: rtl/wb_ram_bank_arbiter.sv
// Round-robin two-master Wishbone classic arbiter/sequencer in front of byte-writable BRAM banks.
// Optional macro WB_RAM_ARB_RANGE_ERR_EN: out-of-range addresses get err instead of aliasing.
module wb_ram_bank_arbiter #(
    parameter int BANK_BITS  = 1,
    parameter int ADDR_WIDTH = 32,
    localparam int NUM_BANKS = 2 ** BANK_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [31:0]             m0_dat_i,
    input  logic [3:0]              m0_sel_i,
    input  logic                    m0_we_i,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    output logic [31:0]             m0_dat_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [31:0]             m1_dat_i,
    input  logic [3:0]              m1_sel_i,
    input  logic                    m1_we_i,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    output logic [31:0]             m1_dat_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic [3:0]              ram_we,
    output logic [31:0]             ram_din,
    output logic [14:0]             ram_waddr,
    output logic [14:0]             ram_raddr,
    output logic [NUM_BANKS-1:0]    ram_bank_select,
    input  logic [32*NUM_BANKS-1:0] ram_dout
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DATA, ST_ACK} state_t;

    state_t                 state_r;
    logic                   last_grant_r;
    logic                   grant_r;
    logic                   we_r;
    logic [BANK_BITS-1:0]   bank_r;
    logic                   ack0_r;
    logic                   ack1_r;
    logic                   err0_r;
    logic                   err1_r;

    logic                   req0_s;
    logic                   req1_s;
    logic                   gnt_valid_s;
    logic                   gnt_s;
    logic [ADDR_WIDTH-1:0]  adr_s;
    logic [31:0]            dat_s;
    logic [3:0]             sel_s;
    logic                   we_s;
    logic [BANK_BITS-1:0]   bank_s;
    logic                   range_err_s;
    logic                   gcyc_s;
    logic [31:0]            rdata_s;
    logic [31:0]            bank_dout_s [NUM_BANKS];
    logic                   unused_adr_s;

    assign req0_s      = m0_cyc_i & m0_stb_i;
    assign req1_s      = m1_cyc_i & m1_stb_i;
    assign gnt_valid_s = req0_s | req1_s;
    assign bank_s      = adr_s[16+BANK_BITS:17];
    assign gcyc_s      = grant_r ? m1_cyc_i : m0_cyc_i;

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank_dout
        assign bank_dout_s[k] = ram_dout[32*k +: 32];
    end
    assign rdata_s = bank_dout_s[bank_r];

`ifdef WB_RAM_ARB_RANGE_ERR_EN
    assign range_err_s = |(adr_s >> (17 + BANK_BITS));
`else
    assign range_err_s = 1'b0;
`endif
    // Byte lane bits and (without range checking) the alias bits never steer anything.
    assign unused_adr_s = ^{adr_s[1:0], adr_s >> (17 + BANK_BITS)};

    // Grant selection: a tie goes to the master that was not granted last.
    always_comb begin
        gnt_s = 1'b0;
        if (req0_s && req1_s) begin
            gnt_s = ~last_grant_r;
        end else if (req1_s) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
        if (gnt_s) begin
            adr_s = m1_adr_i;
            dat_s = m1_dat_i;
            sel_s = m1_sel_i;
            we_s  = m1_we_i;
        end else begin
            adr_s = m0_adr_i;
            dat_s = m0_dat_i;
            sel_s = m0_sel_i;
            we_s  = m0_we_i;
        end
    end

    // Access sequencer: all bank-side controls and master responses are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            last_grant_r    <= 1'b1;
            grant_r         <= 1'b0;
            we_r            <= 1'b0;
            bank_r          <= {BANK_BITS{1'b0}};
            ack0_r          <= 1'b0;
            ack1_r          <= 1'b0;
            err0_r          <= 1'b0;
            err1_r          <= 1'b0;
            m0_dat_o        <= 32'h0;
            m1_dat_o        <= 32'h0;
            ram_we          <= 4'h0;
            ram_bank_select <= {NUM_BANKS{1'b0}};
            ram_din         <= 32'h0;
            ram_waddr       <= 15'h0;
            ram_raddr       <= 15'h0;
        end else begin
            ram_we          <= 4'h0;
            ram_bank_select <= {NUM_BANKS{1'b0}};
            ack0_r          <= 1'b0;
            ack1_r          <= 1'b0;
            err0_r          <= 1'b0;
            err1_r          <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_valid_s) begin
                        grant_r      <= gnt_s;
                        last_grant_r <= gnt_s;
                        we_r         <= we_s;
                        bank_r       <= bank_s;
                        if (range_err_s) begin
                            state_r <= ST_ACK;
                            err0_r  <= ~gnt_s;
                            err1_r  <= gnt_s;
                        end else begin
                            state_r         <= ST_ISSUE;
                            ram_we          <= we_s ? sel_s : 4'h0;
                            ram_bank_select <= NUM_BANKS'(1'b1) << bank_s;
                            ram_waddr       <= adr_s[16:2];
                            ram_raddr       <= adr_s[16:2];
                            ram_din         <= dat_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // A dropped cycle still lets the write land; only the ack is withheld.
                    if (!gcyc_s) begin
                        state_r <= ST_IDLE;
                    end else if (we_r) begin
                        state_r <= ST_ACK;
                        ack0_r  <= ~grant_r;
                        ack1_r  <= grant_r;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!gcyc_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_ACK;
                        ack0_r  <= ~grant_r;
                        ack1_r  <= grant_r;
                        if (grant_r) begin
                            m1_dat_o <= rdata_s;
                        end else begin
                            m0_dat_o <= rdata_s;
                        end
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_ack_o = ack0_r & m0_cyc_i;
    assign m1_ack_o = ack1_r & m1_cyc_i;
    assign m0_err_o = err0_r & m0_cyc_i;
    assign m1_err_o = err1_r & m1_cyc_i;

endmodule

// File: tb/tb_wb_ram_bank_arbiter.sv
// Bench for wb_ram_bank_arbiter: BRAM bank model, transaction-level reference memory,
// directed scenarios plus randomized single-master traffic.
module tb_wb_ram_bank_arbiter;
    localparam int BB = 1;
    localparam int NB = 2 ** BB;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [3:0]  ram_we;
    logic [31:0] ram_din;
    logic [14:0] ram_waddr, ram_raddr;
    logic [NB-1:0] ram_bank_select;
    logic [32*NB-1:0] ram_dout;

    int checks = 0;
    int failures = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] exp_dat [2];

    always #5 clk = ~clk;

    wb_ram_bank_arbiter #(.BANK_BITS(BB), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .ram_we(ram_we), .ram_din(ram_din), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
        .ram_bank_select(ram_bank_select), .ram_dout(ram_dout)
    );

    // BRAM banks: registered read of the old word, byte-lane write, one bank per select bit.
    logic [31:0] bram [int];
    logic [31:0] rd_q [NB];
    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (ram_bank_select[k]) begin
                int rk;
                int wk;
                logic [31:0] w;
                rk = k * 32768 + int'(ram_raddr);
                wk = k * 32768 + int'(ram_waddr);
                rd_q[k] <= bram.exists(rk) ? bram[rk] : 32'h0;
                w = bram.exists(wk) ? bram[wk] : 32'h0;
                for (int b = 0; b < 4; b++) if (ram_we[b]) w[8*b +: 8] = ram_din[8*b +: 8];
                bram[wk] = w;
            end
        end
    end
    for (genvar k = 0; k < NB; k++) begin : g_dout
        assign ram_dout[32*k +: 32] = rd_q[k];
    end

    function automatic int addr_key(input logic [31:0] adr);
        return ((int'(adr >> 17) % NB) * 32768) + int'((adr >> 2) % 32768);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] adr);
        int key;
        key = addr_key(adr);
        return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    endfunction

    task automatic ref_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] w;
        w = ref_read(adr);
        for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
        ref_mem[addr_key(adr)] = w;
    endtask

    task automatic drive(input int m, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic we, input logic req);
        if (m == 0) begin
            m0_adr = adr; m0_dat = dat; m0_sel = sel; m0_we = we; m0_cyc = req; m0_stb = req;
        end else begin
            m1_adr = adr; m1_dat = dat; m1_sel = sel; m1_we = we; m1_cyc = req; m1_stb = req;
        end
    endtask

    // One transaction from a single master with per-cycle checking of the bank bus and both masters.
    task automatic wb_txn(input int m, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic we, input bit exp_err);
        int exp_lat;
        int lat;
        int o;
        logic [31:0] exp_rd;
        logic [NB-1:0] exp_bs;
        logic [3:0] exp_we;
        logic ack_m, err_m, ack_o, err_o;
        logic [31:0] dat_m, dat_oth;
        o = 1 - m;
        exp_lat = exp_err ? 1 : (we ? 2 : 3);
        exp_rd = ref_read(adr);
        exp_bs = NB'(1) << ((adr >> 17) % NB);
        exp_we = we ? sel : 4'h0;
        drive(m, adr, dat, sel, we, 1'b1);
        lat = -1;
        for (int c = 0; c < 10 && lat < 0; c++) begin
            @(negedge clk);
            ack_m = (m == 0) ? m0_ack_o : m1_ack_o;
            err_m = (m == 0) ? m0_err_o : m1_err_o;
            ack_o = (o == 0) ? m0_ack_o : m1_ack_o;
            err_o = (o == 0) ? m0_err_o : m1_err_o;
            dat_oth = (o == 0) ? m0_dat_o : m1_dat_o;
            checks++;
            if (c == 1 && !exp_err) begin
                if (ram_we !== exp_we || ram_bank_select !== exp_bs || ram_waddr !== adr[16:2] ||
                    ram_raddr !== adr[16:2] || ram_din !== dat) begin
                    failures++;
                    $display("FAIL issue_bus: we=%h bs=%b wa=%h ra=%h din=%h expected we=%h bs=%b addr=%h din=%h",
                             ram_we, ram_bank_select, ram_waddr, ram_raddr, ram_din, exp_we, exp_bs, adr[16:2], dat);
                end
            end else if (ram_we !== 4'h0 || ram_bank_select !== {NB{1'b0}}) begin
                failures++;
                $display("FAIL idle_bus: cycle %0d we=%h bs=%b expected 0", c, ram_we, ram_bank_select);
            end
            checks++;
            if (ack_o !== 1'b0 || err_o !== 1'b0 || dat_oth !== exp_dat[o]) begin
                failures++;
                $display("FAIL other_master: ack=%b err=%b dat=%h expected 0/0/%h", ack_o, err_o, dat_oth, exp_dat[o]);
            end
            if (ack_m === 1'b1 || err_m === 1'b1) begin
                lat = c;
                checks++;
                if (ack_m !== !exp_err || err_m !== exp_err) begin
                    failures++;
                    $display("FAIL resp_kind: ack=%b err=%b expected err=%b", ack_m, err_m, exp_err);
                end
            end
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL latency: m%0d got %0d expected %0d", m, lat, exp_lat);
        end
        dat_m = (m == 0) ? m0_dat_o : m1_dat_o;
        if (!we && !exp_err) begin
            checks++;
            if (dat_m !== exp_rd) begin
                failures++;
                $display("FAIL read_data: m%0d adr=%h got %h expected %h", m, adr, dat_m, exp_rd);
            end
            exp_dat[m] = exp_rd;
        end
        if (we && !exp_err) ref_write(adr, dat, sel);
        @(posedge clk);
        #1;
        drive(m, adr, dat, sel, we, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1);
        drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ram_we !== 4'h0 || ram_bank_select !== {NB{1'b0}} || ram_din !== 32'h0 ||
            ram_waddr !== 15'h0 || ram_raddr !== 15'h0) begin
            failures++;
            $display("FAIL reset_bus: we=%h bs=%b din=%h wa=%h ra=%h expected all 0",
                     ram_we, ram_bank_select, ram_din, ram_waddr, ram_raddr);
        end
        checks++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'h0 || m0_dat_o !== 32'h0 || m1_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_resp: acks/errs=%b d0=%h d1=%h expected 0",
                     {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, m0_dat_o, m1_dat_o);
        end
        drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_dat[0] = 32'h0;
        exp_dat[1] = 32'h0;
    endtask

    task automatic test_basic();
        wb_txn(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
        wb_txn(0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0);
        checks++;
        if (m0_dat_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL basic_read: got %h expected deadbeef", m0_dat_o);
        end
    endtask

    task automatic test_byte_write();
        wb_txn(1, 32'h0002_0000, 32'h1122_3344, 4'hF, 1'b1, 1'b0);
        wb_txn(1, 32'h0002_0000, 32'h00AA_0000, 4'b0100, 1'b1, 1'b0);
        wb_txn(1, 32'h0002_0000, 32'h0, 4'h0, 1'b0, 1'b0);
        checks++;
        if (m1_dat_o !== 32'h11AA_3344) begin
            failures++;
            $display("FAIL byte_write: got %h expected 11aa3344", m1_dat_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int m;
            logic [31:0] adr;
            logic [31:0] dat;
            logic [3:0] sel;
            logic we;
            m = int'($urandom_range(0, 1));
            adr = $urandom;
            adr[16:2] = 15'($urandom_range(0, 7));
`ifdef WB_RAM_ARB_RANGE_ERR_EN
            adr[31:18] = 14'h0;
`endif
            dat = $urandom;
            sel = 4'($urandom);
            if (i % 6 == 0) sel = 4'h0;
            we = 1'($urandom);
            wb_txn(m, adr, dat, sel, we, 1'b0);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        logic [31:0] e0, e1;
        test_reset();
        e0 = ref_read(32'h10);
        e1 = ref_read(32'h0002_0000);
        drive(0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1);
        drive(1, 32'h0002_0000, 32'h0, 4'h0, 1'b0, 1'b1);
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            checks++;
            if (m0_ack_o === 1'b1 && m1_ack_o === 1'b1) begin
                failures++;
                $display("FAIL rr_both_ack: both masters acked in cycle %0d", c);
            end
            if (m0_ack_o === 1'b1) begin
                order.push_back(0);
                checks++;
                if (m0_dat_o !== e0) begin
                    failures++;
                    $display("FAIL rr_data0: got %h expected %h", m0_dat_o, e0);
                end
            end
            if (m1_ack_o === 1'b1) begin
                order.push_back(1);
                checks++;
                if (m1_dat_o !== e1) begin
                    failures++;
                    $display("FAIL rr_data1: got %h expected %h", m1_dat_o, e1);
                end
            end
        end
        @(posedge clk);
        #1;
        drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        exp_dat[0] = e0;
        exp_dat[1] = e1;
        checks++;
        if (order.size() != 4) begin
            failures++;
            $display("FAIL rr_count: got %0d acks expected 4", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] != i % 2) begin
                failures++;
                $display("FAIL rr_order: ack %0d went to m%0d expected m%0d", i, order[i], i % 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0 || ram_we !== 4'h0 ||
            ram_bank_select !== {NB{1'b0}} || m0_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: ack0=%b ack1=%b we=%h bs=%b d0=%h expected 0",
                     m0_ack_o, m1_ack_o, ram_we, ram_bank_select, m0_dat_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);
        exp_dat[0] = 32'h0;
        exp_dat[1] = 32'h0;
        wb_txn(0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        int lat;
        lat = -1;
        drive(0, 32'h0000_0040, 32'h5A5A_1234, 4'hF, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        drive(0, 32'h0000_0040, 32'h5A5A_1234, 4'hF, 1'b1, 1'b0);
        drive(1, 32'h0000_0040, 32'h0, 4'h0, 1'b0, 1'b1);
        ref_write(32'h0000_0040, 32'h5A5A_1234, 4'hF);
        for (int c = 2; c < 14 && lat < 0; c++) begin
            @(negedge clk);
            checks++;
            if (m0_ack_o !== 1'b0) begin
                failures++;
                $display("FAIL abort_ack: m0 acked in cycle %0d", c);
            end
            if (m1_ack_o === 1'b1) lat = c;
        end
        checks++;
        if (lat != 5 || m1_dat_o !== 32'h5A5A_1234) begin
            failures++;
            $display("FAIL abort_followup: m1 ack cycle %0d data %h expected 5 / 5a5a1234", lat, m1_dat_o);
        end
        exp_dat[1] = 32'h5A5A_1234;
        @(posedge clk);
        #1;
        drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_range();
        wb_txn(0, 32'h0, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
`ifdef WB_RAM_ARB_RANGE_ERR_EN
        wb_txn(0, 32'h0004_0000, 32'h0, 4'h0, 1'b0, 1'b1);
`else
        wb_txn(0, 32'h0004_0000, 32'h0, 4'h0, 1'b0, 1'b0);
        checks++;
        if (m0_dat_o !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL alias_read: got %h expected cafef00d", m0_dat_o);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        drive(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        exp_dat[0] = 32'h0;
        exp_dat[1] = 32'h0;
        test_reset();
        test_basic();
        test_byte_write();
        test_random();
        test_round_robin();
        test_reset_mid();
        test_abort();
        test_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_ram_bank_arbiter.md
Name: wb_ram_bank_arbiter

Overview:
- Two-master Wishbone (classic, 32-bit) arbiter and sequencer in front of a set of BRAM banks.
- Each bank is a 32-bit wide, 32K-word array with a byte-write port and a registered read output.
- Round-robin grants between master 0 (instruction side) and master 1 (data side).
- Decodes the bank index, drives the bank control bus, waits out the one-cycle BRAM read latency, muxes the read data back and acknowledges the granted master.

Parameters:
BANK_BITS, 1, log2 of bank count; NUM_BANKS = 2**BANK_BITS
ADDR_WIDTH, 32, Wishbone byte-address width; must be >= 17+BANK_BITS

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
m0_adr_i  input  ADDR_WIDTH  master 0 byte address
m0_dat_i  input  32  master 0 write data
m0_sel_i  input  4  master 0 byte selects
m0_we_i  input  1  master 0 write enable
m0_cyc_i  input  1  master 0 cycle
m0_stb_i  input  1  master 0 strobe
m0_dat_o  output  32  master 0 read data
m0_ack_o  output  1  master 0 acknowledge
m0_err_o  output  1  master 0 error (see Optional Feature)
m1_*  same set as m0_*  master 1
ram_we  output  4  byte write enables to banks
ram_din  output  32  write data to banks
ram_waddr  output  15  word write address
ram_raddr  output  15  word read address
ram_bank_select  output  NUM_BANKS  one-hot bank select
ram_dout  input  32*NUM_BANKS  bank read data; bank k on bits [32k+31:32k]

Behaviour:
- Interface: one clock domain (clk); reset rst is synchronous and active-high.
- Address decode:
  - word address = adr[16:2]
  - bank index = adr[16+BANK_BITS:17]
  - adr[1:0] ignored
- Request: mN_cyc_i & mN_stb_i.
- FSM states: IDLE, ISSUE, DATA, ACK.
- IDLE:
  - If one master requests, grant it.
  - If both request, grant the master not granted last (last_grant resets to 1, so m0 wins first tie).
  - Register adr, dat, sel, we and grant; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - ram_bank_select = onehot(bank index).
  - ram_waddr = ram_raddr = registered word address.
  - ram_din = registered data.
  - ram_we = sel if write, else 4'b0.
  - Write: go to ACK. Read: go to DATA.
- DATA: bank outputs now valid. Capture ram_dout of the selected bank into the granted master's dat_o; go to ACK.
- ACK:
  - Granted mN_ack_o = 1 for exactly one cycle. Return to IDLE.
  - The master may present its next request in the following IDLE cycle.
- Latency (request sampled at IDLE edge = cycle 0): write ack in cycle 2, read ack + data in cycle 3.
- Outside ISSUE: ram_we = 0, ram_bank_select = 0; address and data buses hold their last values.
- Abort: if the granted master drops cyc in ISSUE or DATA, the access still completes toward the RAM (write committed), no ack is given, and the FSM returns to IDLE.
- Ack qualification: ack is gated by the granted master's cyc in ACK.
- The non-granted master sees ack = 0 and dat_o unchanged.
- sel = 4'b0 write: no byte written, still acked.
- Address bits above 16+BANK_BITS: ignored (aliasing) without the feature.
- Reset (including mid-transaction):
  - FSM = IDLE, last_grant = 1.
  - All ack/err = 0, mN_dat_o = 0.
  - ram_we = 0, ram_bank_select = 0; ram_din and both addresses = 0.
  - Any in-flight access is dropped.

Optional Feature:
- Macro: WB_RAM_ARB_RANGE_ERR_EN.
- Defined:
  - In IDLE, a granted request with any adr bit above bit 16+BANK_BITS nonzero skips ISSUE (no RAM access, ram_we stays 0).
  - The FSM goes directly to ACK, asserting mN_err_o instead of mN_ack_o for one cycle.
  - Round-robin state updates as normal.
- Not defined: both err outputs tied to 0; such addresses alias into the banks.

Test Plan:
- Reset, then m0 write adr=0x0000_0010, dat=0xDEADBEEF, sel=4'hF -> ram_we=4'hF and waddr=4 in cycle 1, m0_ack_o in cycle 2; m0 read of the same address -> m0_dat_o=0xDEADBEEF with ack in cycle 3.
- m1 byte write sel=4'b0100, dat=0x00AA0000 at adr=0x0002_0000 (BANK_BITS=1) -> ram_bank_select=2'b10, ram_we=4'b0100; readback returns 0xXXAAXXXX with only byte 2 changed.
- m0 and m1 request continuously from reset -> grants alternate m0, m1, m0, m1; each ack goes only to its owner.
- rst asserted in DATA of a read -> next cycle all acks 0, ram_we 0, FSM IDLE; no ack is ever delivered for that read.
- Granted master drops cyc in ISSUE of a write -> data is in RAM (verified by later read), no ack, and the other master is served next.
- With WB_RAM_ARB_RANGE_ERR_EN, read at adr=0x0004_0000 (BANK_BITS=1) -> err one cycle, ack 0, ram_bank_select never asserted. Without the macro -> aliases to bank 0, word 0, acked.
